// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier with start/done handshake and per-operation signed/unsigned mode.
// Defining MULT_TX_EN adds a serial transmitter that sends each product as a start/data/stop frame on tx.
module booth_multiplier_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned TX_DIV = 4
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 tx
);

  localparam int unsigned EW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
`ifdef MULT_TX_EN
  localparam logic [1:0] TX   = 2'd2;
  localparam int unsigned BW = $clog2(PW + 2);
  localparam int unsigned DW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
`endif

  logic [1:0]    state, state_n;
  logic [EW-1:0] a, a_n, q, q_n, m, m_n;
  logic          qm1, qm1_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] product_n;
  logic          busy_n, done_n;

  logic [EW-1:0] sum, a_sh, q_sh;

`ifdef MULT_TX_EN
  logic [PW:0]   txsr, txsr_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          tx_q, tx_n;
`endif

  // One Booth step: conditional add/subtract, then arithmetic shift of {A, Q, q-1}
  always_comb begin
    case ({q[0], qm1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    a_sh = {sum[EW-1], sum[EW-1:1]};
    q_sh = {sum[0], q[EW-1:1]};
  end

  always_comb begin
    state_n   = state;
    a_n       = a;
    q_n       = q;
    m_n       = m;
    qm1_n     = qm1;
    cnt_n     = cnt;
    product_n = product;
    busy_n    = busy;
    done_n    = 1'b0;
`ifdef MULT_TX_EN
    txsr_n    = txsr;
    bcnt_n    = bcnt;
    dcnt_n    = dcnt;
    tx_n      = tx_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          m_n     = {is_signed & multiplicand[WIDTH-1], multiplicand};
          q_n     = {is_signed & multiplier[WIDTH-1], multiplier};
          a_n     = '0;
          qm1_n   = 1'b0;
          cnt_n   = CW'(EW);
          busy_n  = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        a_n   = a_sh;
        q_n   = q_sh;
        qm1_n = q[0];
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          product_n = {a_sh[WIDTH-2:0], q_sh};
          done_n    = 1'b1;
`ifdef MULT_TX_EN
          // Start bit goes out together with done
          state_n = TX;
          tx_n    = 1'b0;
          txsr_n  = {1'b1, a_sh[WIDTH-2:0], q_sh};
          bcnt_n  = BW'(PW + 1);
          dcnt_n  = DW'(TX_DIV - 1);
`else
          state_n = IDLE;
          busy_n  = 1'b0;
`endif
        end
      end
`ifdef MULT_TX_EN
      TX: begin
        if (dcnt == '0) begin
          if (bcnt == '0) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            tx_n    = 1'b1;
          end else begin
            tx_n   = txsr[0];
            txsr_n = {1'b0, txsr[PW:1]};
            bcnt_n = bcnt - BW'(1);
            dcnt_n = DW'(TX_DIV - 1);
          end
        end else begin
          dcnt_n = dcnt - DW'(1);
        end
      end
`endif
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MULT_TX_EN
      txsr    <= '0;
      bcnt    <= '0;
      dcnt    <= '0;
      tx_q    <= 1'b1;
`endif
    end else begin
      state   <= state_n;
      a       <= a_n;
      q       <= q_n;
      m       <= m_n;
      qm1     <= qm1_n;
      cnt     <= cnt_n;
      product <= product_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef MULT_TX_EN
      txsr    <= txsr_n;
      bcnt    <= bcnt_n;
      dcnt    <= dcnt_n;
      tx_q    <= tx_n;
`endif
    end
  end

`ifdef MULT_TX_EN
  assign tx = tx_q;
`else
  assign tx = 1'b1;
`endif

endmodule
